sdram_port_sched: RTL and testbench
===================================

# sdram_port_sched

Four-port burst scheduler sitting between the frame-buffer FIFOs (two write ports, two read ports) and the SDRAM command engine. It selects one eligible port per burst with round-robin fairness and issues a single burst command to the engine. It then tracks the burst to completion and advances that port's circular address pointer. The command engine (init, refresh, row/column sequencing) stays a separate block.

## Interface
Parameters:
- ADDR_W, 24, SDRAM word-address width
- LVL_W, 10, FIFO fill-level width
- LEN_W, 9, burst-length width
- FIFO_DEPTH, 512, read-FIFO capacity in words

Ports (index 0=WR1, 1=WR2, 2=RD1, 3=RD2; packed arrays, port i in slice i):
- clk  in  1  scheduler/SDRAM clock (100 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  SDRAM initialisation finished; no arbitration before it is high
- port_base  in  4*ADDR_W  region start address per port
- port_max  in  4*ADDR_W  region end address (exclusive) per port
- port_len  in  4*LEN_W  burst length per port, 1..2^LEN_W-1
- port_load  in  4  one-cycle pulse; reload that port's pointer to port_base
- port_level  in  4*LVL_W  FIFO fill level: words stored (writes) or words held (reads)
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  engine accepts command when high with cmd_valid
- cmd_write  out  1  1=write burst, 0=read burst
- cmd_addr  out  ADDR_W  burst start address
- cmd_len  out  LEN_W  burst length
- cmd_port  out  2  granted port index
- burst_done  in  1  one-cycle pulse from engine at end of current burst
- grant  out  4  one-hot active port, steers FIFO data muxes; 0 when idle
- busy  out  1  high from grant until pointer update completes

## Operation
- FSM states: WAIT_INIT, ARB, ISSUE, RUN, UPDATE.
- WAIT_INIT: stay until init_done=1, then ARB.
- Eligibility of write ports 0/1: level >= len.
- Eligibility of read ports 2/3: level + len <= FIFO_DEPTH. Compute the sum at LVL_W+1 bits.
- ARB: scan the four ports starting at rr_ptr, wrapping mod 4. Grant the first eligible port, register cmd_* and grant, then go to ISSUE. Stay in ARB if no port is eligible.
- ISSUE: hold cmd_valid=1 with all cmd_* stable until cmd_ready. The command fields never change while valid. On the handshake go to RUN.
- RUN: wait for burst_done. The grant stays asserted.
- UPDATE: next = addr + len. If next >= port_max, next = port_base. Set rr_ptr = granted+1 mod 4, clear grant, return to ARB.
- Per-port address pointer:
  - Reset value is 0.
  - After reset it is loaded with port_base on the first cycle init_done is seen.
- port_load on an idle port reloads its pointer next cycle.
- port_load on the granted port is latched as pending; in UPDATE the pointer becomes port_base instead of being advanced.
- A pending load and a new load on the same port collapse into one.
- burst_done outside RUN is ignored. cmd_ready outside ISSUE is ignored.
- init_done falling while not in WAIT_INIT has no effect; only rst_n restarts.

## Timing
- Reset values: cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_len=0, cmd_port=0, grant=0, busy=0, rr_ptr=0, all pointers 0, FSM=WAIT_INIT.
- Eligible port present in ARB at cycle N gives cmd_valid=1 at N+1.
- cmd_ready at cycle M means cmd_valid drops at M+1.
- burst_done at cycle K gives UPDATE at K+1, a new pointer and grant=0 at K+2, and ARB may grant again at K+2 (next cmd_valid at K+3).
- Minimum spacing between commands is 3 cycles after burst_done.
- Asynchronous reset mid-burst clears everything immediately. The engine must also be reset; no burst recovery is attempted.

## Structure
- Shared package sdram_sched_pkg holds:
  - port index localparams (P_WR1..P_RD2)
  - FSM state enum
  - function is_write(idx) = (idx<2)
- Optional sub-module sdram_rr_pick: combinational 4-way round-robin picker (eligible[3:0], rr_ptr) -> (found, idx). Everything else stays in one module.

## Test plan
- Reset, init_done=0, all ports eligible -> cmd_valid stays 0. Raise init_done -> first command port 0, addr=base0, cmd_write=1.
- All four ports eligible continuously, engine ready immediately, burst_done 4 cycles later -> grants in order 0,1,2,3,0; each port's addr advances by its len.
- Port 2: base=307200, max=614400, len=128; run 2400 bursts -> addr returns to 307200 exactly on burst 2401 with no out-of-range cmd_addr.
- Write port 0 level=255, len=256 -> not granted. Level 256 -> granted. Read port 3 level=385, depth 512, len=128 -> not granted. Level 384 -> granted.
- cmd_ready held low 10 cycles -> cmd_valid and all cmd_* stable for all 10 cycles.
- port_load pulse on port 1 during its RUN -> after UPDATE, pointer=base1 (not base1+len). Assert rst_n=0 mid-RUN -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the four-port SDRAM burst scheduler.
package sdram_sched_pkg;

    localparam logic [1:0] P_WR1 = 2'd0;
    localparam logic [1:0] P_WR2 = 2'd1;
    localparam logic [1:0] P_RD1 = 2'd2;
    localparam logic [1:0] P_RD2 = 2'd3;

    typedef enum logic [2:0] {
        WAIT_INIT,
        ARB,
        ISSUE,
        RUN,
        UPDATE
    } sched_state_e;

    // Ports below the first read port feed write bursts.
    function automatic logic is_write(input logic [1:0] idx);
        return (idx < P_RD1);
    endfunction

endpackage

// File: rtl/sdram_port_sched_rr_pick.sv
// Combinational 4-way round-robin picker: first eligible port at or after rr_ptr.
module sdram_rr_pick (
    input  logic [3:0] eligible,
    input  logic [1:0] rr_ptr,
    output logic       found,
    output logic [1:0] idx
);

    // Scan rr_ptr, rr_ptr+1, ... wrapping mod 4; the 2-bit sum wraps naturally.
    always_comb begin
        found = 1'b0;
        idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && eligible[rr_ptr + 2'(k)]) begin
                found = 1'b1;
                idx   = rr_ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/sdram_port_sched.sv
// Four-port burst scheduler: picks one eligible FIFO port per burst, issues
// a single command to the SDRAM engine and advances that port's pointer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_INIT | SDRAM not initialised; pointers load from port_base on exit
// ARB       | round-robin scan for an eligible port, latch command
// ISSUE     | cmd_valid held with stable fields until cmd_ready
// RUN       | burst in flight, grant steers FIFO muxes until burst_done
// UPDATE    | advance/wrap/reload granted pointer, release grant
module sdram_port_sched
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int LVL_W      = 10,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_done,
    input  logic [4*ADDR_W-1:0] port_base,
    input  logic [4*ADDR_W-1:0] port_max,
    input  logic [4*LEN_W-1:0]  port_len,
    input  logic [3:0]          port_load,
    input  logic [4*LVL_W-1:0]  port_level,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic                cmd_write,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [LEN_W-1:0]    cmd_len,
    output logic [1:0]          cmd_port,
    input  logic                burst_done,
    output logic [3:0]          grant,
    output logic                busy
);

    // Level + length needs one bit of headroom so the read-space test cannot wrap.
    localparam int SUM_W = LVL_W + 1;

    logic [ADDR_W-1:0] base_w [4];
    logic [ADDR_W-1:0] max_w  [4];
    logic [LEN_W-1:0]  len_w  [4];
    logic [LVL_W-1:0]  lvl_w  [4];
    logic [3:0]        elig;
    logic              pick_found;
    logic [1:0]        pick_idx;
    logic              take;
    logic [ADDR_W:0]   nxt_addr;

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q [4];
    logic [ADDR_W-1:0] ptr_d [4];
    logic [3:0]        pend_q, pend_d;
    logic [1:0]        rr_q, rr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic [1:0]        cmd_port_q, cmd_port_d;
    logic [3:0]        grant_q, grant_d;
    logic              busy_q, busy_d;

    // Unpack per-port fields and decide which FIFOs can take a full burst.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            base_w[i] = port_base[i*ADDR_W +: ADDR_W];
            max_w[i]  = port_max[i*ADDR_W +: ADDR_W];
            len_w[i]  = port_len[i*LEN_W +: LEN_W];
            lvl_w[i]  = port_level[i*LVL_W +: LVL_W];
            if (is_write(2'(i)))
                elig[i] = SUM_W'(lvl_w[i]) >= SUM_W'(len_w[i]);
            else
                elig[i] = (SUM_W'(lvl_w[i]) + SUM_W'(len_w[i])) <= SUM_W'(FIFO_DEPTH);
        end
    end

    sdram_rr_pick u_pick (
        .eligible (elig),
        .rr_ptr   (rr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign take     = (state_q == ARB) && pick_found;
    assign nxt_addr = {1'b0, cmd_addr_q} + (ADDR_W+1)'(cmd_len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic; stray cmd_ready/burst_done only matter in their own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INIT: if (init_done)  state_d = ARB;
            ARB:       if (pick_found) state_d = ISSUE;
            ISSUE:     if (cmd_ready)  state_d = RUN;
            RUN:       if (burst_done) state_d = UPDATE;
            UPDATE:                    state_d = ARB;
            default:                   state_d = WAIT_INIT;
        endcase
    end

    // Command, grant and pointer next values.
    always_comb begin
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        rr_d        = rr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        cmd_port_d  = cmd_port_q;
        grant_d     = grant_q;
        busy_d      = busy_q;

        if (state_q == WAIT_INIT && init_done) begin
            for (int i = 0; i < 4; i++) ptr_d[i] = base_w[i];
        end

        // A port whose burst is being latched or in flight defers its reload to UPDATE.
        for (int i = 0; i < 4; i++) begin
            if (port_load[i]) begin
                if (grant_q[i] || (take && pick_idx == 2'(i))) pend_d[i] = 1'b1;
                else                                            ptr_d[i]  = base_w[i];
            end
        end

        case (state_q)
            ARB: begin
                if (pick_found) begin
                    cmd_valid_d = 1'b1;
                    cmd_write_d = is_write(pick_idx);
                    cmd_addr_d  = ptr_q[pick_idx];
                    cmd_len_d   = len_w[pick_idx];
                    cmd_port_d  = pick_idx;
                    grant_d     = 4'b0001 << pick_idx;
                    busy_d      = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_ready) cmd_valid_d = 1'b0;
            end
            UPDATE: begin
                if (pend_q[cmd_port_q] || port_load[cmd_port_q] ||
                    nxt_addr >= {1'b0, max_w[cmd_port_q]})
                    ptr_d[cmd_port_q] = base_w[cmd_port_q];
                else
                    ptr_d[cmd_port_q] = nxt_addr[ADDR_W-1:0];
                pend_d[cmd_port_q] = 1'b0;
                rr_d               = cmd_port_q + 2'd1;
                grant_d            = 4'b0000;
                busy_d             = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers; async reset drops the command and grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ptr_q[i] <= '0;
            pend_q      <= '0;
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_port_q  <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            cmd_port_q  <= cmd_port_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign cmd_port  = cmd_port_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched: arbitration order, eligibility edges,
// command stability, pointer wrap, deferred reload and async reset.
module tb_sdram_port_sched;

    localparam int ADDR_W     = 24;
    localparam int LVL_W      = 10;
    localparam int LEN_W      = 9;
    localparam int FIFO_DEPTH = 512;

    logic                clk;
    logic                rst_n;
    logic                init_done;
    logic [4*ADDR_W-1:0] port_base;
    logic [4*ADDR_W-1:0] port_max;
    logic [4*LEN_W-1:0]  port_len;
    logic [3:0]          port_load;
    logic [4*LVL_W-1:0]  port_level;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic [1:0]          cmd_port;
    logic                burst_done;
    logic [3:0]          grant;
    logic                busy;

    logic [ADDR_W-1:0] base_a  [4];
    logic [ADDR_W-1:0] max_a   [4];
    logic [LEN_W-1:0]  len_a   [4];
    logic [LVL_W-1:0]  lvl_a   [4];
    logic [ADDR_W-1:0] exp_ptr [4];

    int  n_vec;
    int  n_err;
    bit  dead;

    assign port_base  = {base_a[3], base_a[2], base_a[1], base_a[0]};
    assign port_max   = {max_a[3],  max_a[2],  max_a[1],  max_a[0]};
    assign port_len   = {len_a[3],  len_a[2],  len_a[1],  len_a[0]};
    assign port_level = {lvl_a[3],  lvl_a[2],  lvl_a[1],  lvl_a[0]};

    sdram_port_sched #(
        .ADDR_W     (ADDR_W),
        .LVL_W      (LVL_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .port_base  (port_base),
        .port_max   (port_max),
        .port_len   (port_len),
        .port_load  (port_load),
        .port_level (port_level),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_port   (cmd_port),
        .burst_done (burst_done),
        .grant      (grant),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_levels();
        lvl_a[0] = '0;
        lvl_a[1] = '0;
        lvl_a[2] = LVL_W'(FIFO_DEPTH);
        lvl_a[3] = LVL_W'(FIFO_DEPTH);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!cmd_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("cmd_valid_seen", cmd_valid, 1);
        if (!cmd_valid) dead = 1'b1;
    endtask

    // One complete burst on port p; hold = cycles cmd_ready stays low,
    // run = RUN cycles before burst_done, ld = port_load pulse during RUN.
    task automatic do_burst(input int p, input int hold, input int run, input bit ld,
                            output logic [ADDR_W-1:0] addr_seen, output int lat);
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W:0]   nxt;
        addr_seen = '0;
        wait_valid(lat);
        if (dead) return;
        ea = exp_ptr[p];
        addr_seen = cmd_addr;
        chk("cmd_port",  cmd_port, p);
        chk("cmd_addr",  cmd_addr, ea);
        chk("cmd_len",   cmd_len, len_a[p]);
        chk("cmd_write", cmd_write, (p < 2) ? 1 : 0);
        chk("grant",     grant, 32'(4'b0001 << p));
        chk("busy",      busy, 1);
        for (int c = 0; c < hold; c++) begin
            burst_done = (c == 3);
            tick();
            burst_done = 1'b0;
            chk("hold_valid", cmd_valid, 1);
            chk("hold_addr",  cmd_addr, ea);
            chk("hold_len",   cmd_len, len_a[p]);
            chk("hold_port",  cmd_port, p);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("valid_drop", cmd_valid, 0);
        chk("grant_run",  grant, 32'(4'b0001 << p));
        for (int c = 0; c < run; c++) begin
            port_load = (ld && c == 0) ? (4'b0001 << p) : 4'b0000;
            tick();
            port_load = 4'b0000;
        end
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk("grant_upd", grant, 32'(4'b0001 << p));
        tick();
        chk("grant_clr", grant, 0);
        chk("busy_clr",  busy, 0);
        nxt = {1'b0, ea} + (ADDR_W+1)'(len_a[p]);
        if (ld || nxt >= {1'b0, max_a[p]}) exp_ptr[p] = base_a[p];
        else                               exp_ptr[p] = nxt[ADDR_W-1:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] seen;
        int lat;
        int exp_order [5];

        n_vec = 0;
        n_err = 0;
        dead  = 1'b0;
        rst_n      = 1'b0;
        init_done  = 1'b0;
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
        port_load  = 4'b0000;
        base_a = '{24'd1000,   24'd2000,   24'd307200, 24'd700000};
        max_a  = '{24'd100000, 24'd200000, 24'd614400, 24'd800000};
        len_a  = '{9'd16, 9'd32, 9'd64, 9'd128};
        lvl_a  = '{10'd512, 10'd512, 10'd0, 10'd0};
        exp_ptr = base_a;

        #3;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_addr",  cmd_addr, 0);
        tick();
        rst_n = 1'b1;

        // All ports eligible but SDRAM not initialised: nothing may issue.
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("noinit_valid", cmd_valid, 0);
        end

        // First command two cycles after init_done: port 0 at base0, write.
        init_done = 1'b1;
        do_burst(0, 0, 4, 1'b0, seen, lat);
        chk("init_lat",  lat, 2);
        chk("init_addr", seen, 1000);

        // Continuous eligibility: strict rotation, one-cycle re-arbitration.
        exp_order = '{1, 2, 3, 0, 1};
        for (int b = 0; b < 5 && !dead; b++) begin
            do_burst(exp_order[b], 0, 4, 1'b0, seen, lat);
            chk("rr_lat", lat, 1);
        end
        chk("rr_addr0_adv", exp_ptr[0], 1032);
        set_idle_levels();

        // Stalled engine: fields stable for 10 cycles, stray burst_done ignored.
        lvl_a[1] = 10'd512;
        do_burst(1, 10, 4, 1'b0, seen, lat);
        chk("stall_addr", seen, 2064);

        // Reload during RUN lands on base instead of base+len.
        do_burst(1, 0, 3, 1'b1, seen, lat);
        do_burst(1, 0, 2, 1'b0, seen, lat);
        chk("load_addr", seen, 2000);
        set_idle_levels();

        // Write eligibility edge: level 255 < len 256, then 256.
        len_a[0] = 9'd256;
        lvl_a[0] = 10'd255;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("wr_edge_idle", cmd_valid, 0);
        end
        lvl_a[0] = 10'd256;
        do_burst(0, 0, 2, 1'b0, seen, lat);
        chk("wr_edge_addr", seen, 1032);
        lvl_a[0] = '0;

        // Read eligibility edge: 385+128 > 512, 384+128 == 512.
        lvl_a[3] = 10'd385;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rd_edge_idle", cmd_valid, 0);
        end
        lvl_a[3] = 10'd384;
        do_burst(3, 0, 2, 1'b0, seen, lat);
        chk("rd_edge_addr", seen, 700128);
        set_idle_levels();

        // Port 2 region walk: 2400 bursts of 128 fill it, burst 2401 wraps.
        len_a[2]  = 9'd128;
        port_load = 4'b0100;
        tick();
        port_load = 4'b0000;
        exp_ptr[2] = base_a[2];
        lvl_a[2] = '0;
        for (int b = 0; b < 2401 && !dead; b++) begin
            do_burst(2, 0, 1, 1'b0, seen, lat);
            chk("wrap_in_range", (seen >= 24'd307200 && seen < 24'd614400) ? 1 : 0, 1);
            if (b == 2399) chk("wrap_last", seen, 614272);
            if (b == 2400) chk("wrap_addr", seen, 307200);
        end
        set_idle_levels();

        // Async reset mid-RUN clears outputs without waiting for a clock.
        lvl_a[1] = 10'd512;
        wait_valid(lat);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        chk("pre_rst_grant", grant, 2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", cmd_valid, 0);
        chk("arst_write", cmd_write, 0);
        chk("arst_addr",  cmd_addr, 0);
        chk("arst_len",   cmd_len, 0);
        chk("arst_port",  cmd_port, 0);
        chk("arst_grant", grant, 0);
        chk("arst_busy",  busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
